wb_trace_fifo: RTL and testbench

- Captures every register-file write retired by the WB stage of the pipelined datapath (register number, write data, PC+4 of the retiring instruction, cycle stamp) into a FIFO.
- Presents the captured events on a valid/ready stream so a bench or debug port can drain them.
- Sits beside the register file and observes the same WB-stage signals. It never drives the datapath.
- Gives SAD-program runs an ordered, lossless-or-flagged write log in place of poking v0out/v1out.

---
 rtl/wb_trace_fifo.sv | 94 +++++++++
 tb/tb_wb_trace_fifo.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: FWFT trace FIFO of WB-stage register writes; define TRACE_V_ONLY_EN to log only $v0/$v1
module wb_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regWriteWB,
  input  logic [4:0]        writeRegWB,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] pcResultPlus4wb,
  input  logic              clear,
  input  logic              trace_ready,
  output logic              trace_valid,
  output logic [4:0]        trace_reg,
  output logic [DATA_W-1:0] trace_data,
  output logic [DATA_W-1:0] trace_pc,
  output logic [31:0]       trace_cycle,
  output logic [ADDR_W:0]   fill_level,
  output logic              overflow,
  output logic [15:0]       drop_count
);
  logic [4:0]        r_reg  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DATA_W-1:0] r_pc   [DEPTH];
  logic [31:0]       r_cyc  [DEPTH];
  logic [ADDR_W-1:0] r_wptr, r_rptr;
  logic [ADDR_W:0]   r_fill;
  logic [31:0]       r_cnt;
  logic              r_ovf;
  logic [15:0]       r_drop;
  logic              w_event, w_full, w_pop, w_push, w_drop;

`ifdef TRACE_V_ONLY_EN
  assign w_event = regWriteWB && (writeRegWB == 5'd2 || writeRegWB == 5'd3);
`else
  assign w_event = regWriteWB && writeRegWB != 5'd0;
`endif
  assign w_full = r_fill == (ADDR_W+1)'(DEPTH);
  assign w_pop  = trace_valid && trace_ready;
  assign w_push = w_event && (!w_full || w_pop);
  assign w_drop = w_event && w_full && !w_pop;

  // Entry storage; contents are don't-care until marked valid by the fill level
  always_ff @(posedge clk) begin
    if (w_push && !clear && !rst) begin
      r_reg[r_wptr]  <= writeRegWB;
      r_data[r_wptr] <= WriteData;
      r_pc[r_wptr]   <= pcResultPlus4wb;
      r_cyc[r_wptr]  <= r_cnt;
    end
  end

  // Pointers, occupancy, cycle stamp and drop bookkeeping; clear leaves the stamp running
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      if (clear) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_fill <= '0;
        r_ovf  <= 1'b0;
        r_drop <= '0;
      end else begin
        r_wptr <= r_wptr + ADDR_W'(w_push);
        r_rptr <= r_rptr + ADDR_W'(w_pop);
        r_fill <= r_fill + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);
        r_ovf  <= r_ovf || w_drop;
        r_drop <= r_drop + 16'(w_drop && r_drop != 16'hFFFF);
      end
    end
  end

  // Head fields are masked to zero while empty
  always_comb begin
    trace_valid = r_fill != '0;
    trace_reg   = trace_valid ? r_reg[r_rptr]  : '0;
    trace_data  = trace_valid ? r_data[r_rptr] : '0;
    trace_pc    = trace_valid ? r_pc[r_rptr]   : '0;
    trace_cycle = trace_valid ? r_cyc[r_rptr]  : '0;
  end

  assign fill_level = r_fill;
  assign overflow   = r_ovf;
  assign drop_count = r_drop;
endmodule

// File: tb/tb_wb_trace_fifo.sv
// tb_wb_trace_fifo: directed checks of the WB trace FIFO
module tb_wb_trace_fifo;
  logic        clk = 0, rst = 1;
  logic        regWriteWB = 0, clear = 0, trace_ready = 0;
  logic [4:0]  writeRegWB = 0;
  logic [31:0] WriteData = 0, pcResultPlus4wb = 0;
  logic        trace_valid, overflow;
  logic [4:0]  trace_reg;
  logic [31:0] trace_data, trace_pc, trace_cycle;
  logic [4:0]  fill_level;
  logic [15:0] drop_count;
  int          n_pass = 0, n_total = 0;
  logic [31:0] cyc = 0, stamp;

  wb_trace_fifo dut (
    .clk(clk), .rst(rst), .regWriteWB(regWriteWB), .writeRegWB(writeRegWB),
    .WriteData(WriteData), .pcResultPlus4wb(pcResultPlus4wb), .clear(clear),
    .trace_ready(trace_ready), .trace_valid(trace_valid), .trace_reg(trace_reg),
    .trace_data(trace_data), .trace_pc(trace_pc), .trace_cycle(trace_cycle),
    .fill_level(fill_level), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc = rst ? 32'd0 : cyc + 32'd1;
  endtask

  task automatic ev(input logic [4:0] r, input logic [31:0] d);
    regWriteWB = 1; writeRegWB = r; WriteData = d; pcResultPlus4wb = d + 32'h100;
    tick;
    regWriteWB = 0;
  endtask

  initial begin
    tick; tick;
    rst = 0;
    chk("rst_valid", trace_valid, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_data", trace_data, 0);
    chk("rst_cycle", trace_cycle, 0);
    repeat (5) tick;
    regWriteWB = 1; writeRegWB = 2; WriteData = 32'h2A; pcResultPlus4wb = 32'h10;
    tick;
    regWriteWB = 0;
    chk("first_valid", trace_valid, 1);
    chk("first_reg", trace_reg, 2);
    chk("first_data", trace_data, 32'h2A);
    chk("first_pc", trace_pc, 32'h10);
    chk("first_cycle", trace_cycle, 5);
    chk("first_fill", fill_level, 1);
    tick;
    chk("hold_data", trace_data, 32'h2A);
    trace_ready = 1;
    tick;
    trace_ready = 0;
    chk("pop_empty", trace_valid, 0);
    regWriteWB = 1; writeRegWB = 0; WriteData = 7;
    tick;
    regWriteWB = 0; writeRegWB = 5;
    tick;
    chk("nocap_valid", trace_valid, 0);
    chk("nocap_fill", fill_level, 0);
    for (int i = 1; i <= 18; i++) ev(5'd9, i);
    chk("ovf_fill", fill_level, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_count, 2);
    trace_ready = 1;
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("drain_%0d", i), trace_data, i);
      tick;
    end
    trace_ready = 0;
    chk("drain_empty", trace_valid, 0);
    chk("ovf_sticky", overflow, 1);
    clear = 1;
    tick;
    clear = 0;
    chk("clr_ovf", overflow, 0);
    chk("clr_drop", drop_count, 0);
    for (int i = 0; i < 16; i++) ev(5'd4, 100 + i);
    chk("full_fill", fill_level, 16);
    trace_ready = 1;
    ev(5'd6, 32'hBEEF);
    chk("fullpp_fill", fill_level, 16);
    chk("fullpp_ovf", overflow, 0);
    chk("fullpp_head", trace_data, 101);
    for (int i = 101; i < 116; i++) tick;
    chk("fullpp_last", trace_data, 32'hBEEF);
    chk("fullpp_reg", trace_reg, 6);
    tick;
    trace_ready = 0;
    chk("fullpp_empty", trace_valid, 0);
    for (int i = 0; i < 5; i++) ev(5'd7, i);
    chk("five_fill", fill_level, 5);
    clear = 1;
    ev(5'd8, 32'h55);
    clear = 0;
    chk("clr_fill", fill_level, 0);
    chk("clr_valid", trace_valid, 0);
    chk("clr_drop2", drop_count, 0);
    stamp = cyc;
    ev(5'd10, 32'h77);
    chk("cnt_runs", trace_cycle, stamp);
    trace_ready = 1;
    tick;
    trace_ready = 0;
    ev(5'd2, 1); ev(5'd8, 2); ev(5'd3, 3); ev(5'd31, 4);
`ifdef TRACE_V_ONLY_EN
    chk("vonly_fill", fill_level, 2);
    chk("vonly_drop", drop_count, 0);
    chk("vonly_r0", trace_reg, 2);
    trace_ready = 1;
    tick;
    chk("vonly_r1", trace_reg, 3);
`else
    chk("all_fill", fill_level, 4);
    chk("all_r0", trace_reg, 2);
    trace_ready = 1;
    tick;
    chk("all_r1", trace_reg, 8);
`endif
    trace_ready = 0;
    rst = 1;
    tick;
    rst = 0;
    chk("rst2_fill", fill_level, 0);
    ev(5'd12, 32'h99);
    chk("rst2_data", trace_data, 32'h99);
    chk("rst2_cycle", trace_cycle, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
